interrupt_priority_resolver: RTL and testbench

Upstream stage of the in-service register. It holds the interrupt request register (IRR) and applies the IMR mask. It resolves the highest-priority pending IR under the current rotation, checking it against isrRegValue for fully nested blocking. It drives INT and runs the INTA handshake that hands toSet/readPriority/zeroLevelIndex to the in-service register.

---
 rtl/interrupt_priority_resolver.sv | 160 ++++++++++++++++
 tb/tb_interrupt_priority_resolver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_priority_resolver.sv
// Interrupt priority resolver: holds the IRR, applies the IMR mask, picks the
// highest-priority pending request under the current rotation (with
// fully nested blocking against the in-service bits), drives INT and runs the
// two-pulse INTA handshake that hands the granted index to the ISR.
//
// Handshake: INT rises one edge after a valid winner appears and is held until
// firstACK. At firstACK the winner (or SPURIOUS_INDEX when nothing valid
// remains) is latched into toSet with a one-cycle readPriority (or spurious)
// strobe. INT stays low until secondACK returns the FSM to IDLE.
module interrupt_priority_resolver #(
  parameter logic [2:0] SPURIOUS_INDEX = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic       LTIM,
  input  logic [7:0] IMR,
  input  logic       specialMask,
  input  logic [7:0] isrRegValue,
  input  logic       firstACK,
  input  logic       secondACK,
  input  logic       rotate,
  input  logic [2:0] rotateIndex,
  output logic       INT,
  output logic [2:0] toSet,
  output logic       readPriority,
  output logic [2:0] zeroLevelIndex,
  output logic       spurious,
  output logic [7:0] irrValue
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT2 = 2'd2
  } state_t;

  state_t     state;
  state_t     stateNext;
  logic [7:0] irr;
  logic [7:0] irPrev;
  logic [7:0] irrNext;
  logic [7:0] cand;
  logic [7:0] clrMask;
  logic [2:0] winner;
  logic       winnerValid;
  logic       blocked;
  logic [2:0] scanIdx;
  logic       ackGrant;
  logic       ackSpurious;

  assign irrValue = irr;

  // Candidate set and circular priority scan starting at zeroLevelIndex.
  always_comb begin
    cand        = irr & ~IMR & (specialMask ? ~isrRegValue : 8'hFF);
    winner      = 3'd0;
    winnerValid = 1'b0;
    blocked     = 1'b0;
    scanIdx     = 3'd0;
    for (int k = 0; k < 8; k++) begin
      scanIdx = zeroLevelIndex + 3'(k);
      if (!winnerValid && !blocked) begin
        // An in-service bit at or above the candidate blocks it in nested mode.
        if (!specialMask && isrRegValue[scanIdx]) begin
          blocked = 1'b1;
        end else if (cand[scanIdx]) begin
          winner      = scanIdx;
          winnerValid = 1'b1;
        end
      end
    end
  end

  // Acknowledge decode and the IRR next value (edge vs level capture).
  always_comb begin
    ackGrant    = firstACK && (state == REQ) && winnerValid;
    ackSpurious = firstACK && ((state == IDLE) || ((state == REQ) && !winnerValid));
    clrMask     = (ackGrant && !LTIM) ? (8'b1 << winner) : 8'h00;
    if (LTIM) begin
      irrNext = IR;
    end else begin
      irrNext = IR & (~irPrev | irr) & ~clrMask;
    end
  end

  // IRR, edge-detect history and rotation pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      irr            <= 8'h00;
      irPrev         <= 8'h00;
      zeroLevelIndex <= 3'd0;
    end else begin
      irr    <= irrNext;
      irPrev <= IR;
      if (rotate) begin
        zeroLevelIndex <= rotateIndex + 3'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (firstACK) begin
          stateNext = WAIT2;
        end else if (winnerValid) begin
          stateNext = REQ;
        end
      end
      REQ: begin
        if (firstACK) begin
          stateNext = WAIT2;
        end
      end
      WAIT2: begin
        if (secondACK) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // FSM outputs: INT is asserted exactly while waiting for the first INTA.
  always_comb begin
    INT = (state == REQ);
  end

  // Grant register and one-cycle strobes toward the in-service register.
  always_ff @(posedge clk) begin
    if (reset) begin
      toSet        <= 3'd0;
      readPriority <= 1'b0;
      spurious     <= 1'b0;
    end else begin
      readPriority <= 1'b0;
      spurious     <= 1'b0;
      if (ackGrant) begin
        toSet        <= winner;
        readPriority <= 1'b1;
      end else if (ackSpurious) begin
        toSet    <= SPURIOUS_INDEX;
        spurious <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_priority_resolver.sv
// Directed bench for interrupt_priority_resolver with hand-computed expectations.
module tb_interrupt_priority_resolver;

  logic       clk;
  logic       reset;
  logic [7:0] IR;
  logic       LTIM;
  logic [7:0] IMR;
  logic       specialMask;
  logic [7:0] isrRegValue;
  logic       firstACK;
  logic       secondACK;
  logic       rotate;
  logic [2:0] rotateIndex;
  logic       INT;
  logic [2:0] toSet;
  logic       readPriority;
  logic [2:0] zeroLevelIndex;
  logic       spurious;
  logic [7:0] irrValue;

  int n_checks = 0;
  int n_fails  = 0;

  interrupt_priority_resolver dut (
    .clk(clk), .reset(reset), .IR(IR), .LTIM(LTIM), .IMR(IMR),
    .specialMask(specialMask), .isrRegValue(isrRegValue),
    .firstACK(firstACK), .secondACK(secondACK), .rotate(rotate),
    .rotateIndex(rotateIndex), .INT(INT), .toSet(toSet),
    .readPriority(readPriority), .zeroLevelIndex(zeroLevelIndex),
    .spurious(spurious), .irrValue(irrValue)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse firstACK for one edge.
  task automatic ack1();
    firstACK = 1'b1;
    tick();
    firstACK = 1'b0;
  endtask

  // Pulse secondACK for one edge.
  task automatic ack2();
    secondACK = 1'b1;
    tick();
    secondACK = 1'b0;
  endtask

  task automatic do_rotate(input logic [2:0] idx);
    rotate      = 1'b1;
    rotateIndex = idx;
    tick();
    rotate      = 1'b0;
  endtask

  initial begin
    reset = 1'b1; IR = 8'h00; LTIM = 1'b0; IMR = 8'h00; specialMask = 1'b0;
    isrRegValue = 8'h00; firstACK = 1'b0; secondACK = 1'b0; rotate = 1'b0;
    rotateIndex = 3'd0;
    tick(); tick();
    check("rst_int", 8'(INT), 8'h0);
    check("rst_toset", 8'(toSet), 8'h0);
    check("rst_zli", 8'(zeroLevelIndex), 8'h0);
    check("rst_irr", irrValue, 8'h00);
    check("rst_rp", 8'(readPriority), 8'h0);
    check("rst_spur", 8'(spurious), 8'h0);
    reset = 1'b0;

    // Edge mode single request on IR3.
    IR = 8'h08;
    tick();
    check("t1_irr_set", irrValue, 8'h08);
    check("t1_int_lat", 8'(INT), 8'h0);
    tick();
    check("t1_int", 8'(INT), 8'h1);
    ack1();
    check("t1_toset", 8'(toSet), 8'h3);
    check("t1_rp", 8'(readPriority), 8'h1);
    check("t1_int_drop", 8'(INT), 8'h0);
    check("t1_irr_clr", irrValue, 8'h00);
    tick();
    check("t1_rp_pulse", 8'(readPriority), 8'h0);
    ack2();
    tick();
    check("t1_idle_int", 8'(INT), 8'h0);
    IR = 8'h00;
    tick();

    // IR2 and IR5 together: 2 wins; then fully nested blocking of 5.
    IR = 8'h24;
    tick();
    tick();
    check("t2_int", 8'(INT), 8'h1);
    ack1();
    check("t2_toset", 8'(toSet), 8'h2);
    check("t2_irr", irrValue, 8'h20);
    isrRegValue = 8'h04;
    tick();
    check("t2_wait_int", 8'(INT), 8'h0);
    ack2();
    tick();
    check("t2_nested_blk", 8'(INT), 8'h0);
    tick();
    check("t2_nested_blk2", 8'(INT), 8'h0);
    specialMask = 1'b1;
    tick();
    check("t2_smm_int", 8'(INT), 8'h1);
    ack1();
    check("t2_toset5", 8'(toSet), 8'h5);
    ack2();
    specialMask = 1'b0; isrRegValue = 8'h00; IR = 8'h00;
    tick();

    // Rotation: IR5 highest, IR1 and IR6 pending -> 6 then 1.
    do_rotate(3'd4);
    check("t3_zli5", 8'(zeroLevelIndex), 8'h5);
    IR = 8'h42;
    tick();
    tick();
    check("t3_int", 8'(INT), 8'h1);
    ack1();
    check("t3_toset6", 8'(toSet), 8'h6);
    ack2();
    tick();
    check("t3_int_again", 8'(INT), 8'h1);
    ack1();
    check("t3_toset1", 8'(toSet), 8'h1);
    ack2();
    IR = 8'h00;
    do_rotate(3'd7);
    check("t3_zli0", 8'(zeroLevelIndex), 8'h0);

    // Withdrawal in REQ gives a spurious response.
    IR = 8'h10;
    tick();
    tick();
    check("t4_int", 8'(INT), 8'h1);
    IR = 8'h00;
    tick();
    check("t4_int_held", 8'(INT), 8'h1);
    check("t4_irr", irrValue, 8'h00);
    ack1();
    check("t4_toset", 8'(toSet), 8'h7);
    check("t4_spur", 8'(spurious), 8'h1);
    check("t4_rp", 8'(readPriority), 8'h0);
    tick();
    check("t4_spur_pulse", 8'(spurious), 8'h0);
    ack2();

    // Stray firstACK in IDLE is a spurious grant.
    ack1();
    check("t5_stray_spur", 8'(spurious), 8'h1);
    check("t5_stray_int", 8'(INT), 8'h0);
    ack2();

    // Level mode with IR0 masked, then unmasked.
    LTIM = 1'b1; IMR = 8'h01; IR = 8'h01;
    tick();
    tick();
    check("t6_masked_int", 8'(INT), 8'h0);
    check("t6_irr", irrValue, 8'h01);
    IMR = 8'h00;
    tick();
    check("t6_int", 8'(INT), 8'h1);
    ack1();
    check("t6_toset0", 8'(toSet), 8'h0);
    check("t6_rp", 8'(readPriority), 8'h1);
    ack2();
    check("t6_irr_kept", irrValue, 8'h01);
    tick();
    check("t6_rereq", 8'(INT), 8'h1);
    ack1();

    // Reset while in WAIT2; held IR0 re-triggers in edge mode.
    LTIM = 1'b0;
    do_rotate(3'd2);
    check("t7_zli3", 8'(zeroLevelIndex), 8'h3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t7_rst_int", 8'(INT), 8'h0);
    check("t7_rst_toset", 8'(toSet), 8'h0);
    check("t7_rst_zli", 8'(zeroLevelIndex), 8'h0);
    check("t7_rst_irr", irrValue, 8'h00);
    tick();
    check("t7_retrig_irr", irrValue, 8'h01);
    tick();
    check("t7_retrig_int", 8'(INT), 8'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
